regfile_wb_arbiter: RTL and testbench



---
 rtl/regfile_wb_arbiter.sv | 109 ++++++++++
 tb/tb_regfile_wb_arbiter.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter sharing the register-file write port between ALU (port 0)
// and LSU (port 1), with a pending-write busy scoreboard. Optional WB_BYPASS_EN.
module regfile_wb_arbiter #(
  parameter int unsigned N = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [4:0]   req0_rd,
  input  logic [N-1:0] req0_data,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [4:0]   req1_rd,
  input  logic [N-1:0] req1_data,
  input  logic         reserve_valid,
  input  logic [4:0]   reserve_rd,
  output logic [4:0]   rf_rd,
  output logic [N-1:0] rf_write_data,
  output logic         rf_write_enable,
  output logic [31:0]  busy
`ifdef WB_BYPASS_EN
  ,
  input  logic [4:0]   bp_rs1,
  input  logic [4:0]   bp_rs2,
  output logic         bp_hit1,
  output logic         bp_hit2,
  output logic [N-1:0] bp_data1,
  output logic [N-1:0] bp_data2
`endif
);

  logic         last_grant_q, last_grant_d;
  logic [4:0]   rf_rd_q, rf_rd_d;
  logic [N-1:0] rf_data_q, rf_data_d;
  logic         rf_we_q, rf_we_d;
  logic [31:0]  busy_q, busy_d;

  logic         grant0_c, grant1_c, xfer_c;
  logic [4:0]   sel_rd_c;
  logic [N-1:0] sel_data_c;

  // Port 1 wins when alone, or when both request and port 0 went last.
  always_comb begin
    grant1_c   = req1_valid & (~req0_valid | ~last_grant_q);
    grant0_c   = req0_valid & ~grant1_c;
    xfer_c     = grant0_c | grant1_c;
    sel_rd_c   = grant1_c ? req1_rd : req0_rd;
    sel_data_c = grant1_c ? req1_data : req0_data;
  end

  assign req0_ready = grant0_c;
  assign req1_ready = grant1_c;

  always_comb begin
    last_grant_d = last_grant_q;
    rf_rd_d      = rf_rd_q;
    rf_data_d    = rf_data_q;
    rf_we_d      = 1'b0;
    if (xfer_c) begin
      last_grant_d = grant1_c;
      rf_rd_d      = sel_rd_c;
      rf_data_d    = sel_data_c;
      rf_we_d      = (sel_rd_c != 5'd0);
    end
  end

  // Clear first so that a same-edge reservation of the register wins.
  always_comb begin
    busy_d = busy_q;
`ifdef WB_BYPASS_EN
    if (xfer_c) busy_d[sel_rd_c] = 1'b0;
`else
    if (rf_we_q) busy_d[rf_rd_q] = 1'b0;
`endif
    if (reserve_valid && (reserve_rd != 5'd0)) busy_d[reserve_rd] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant_q <= 1'b1;
      rf_rd_q      <= 5'd0;
      rf_data_q    <= '0;
      rf_we_q      <= 1'b0;
      busy_q       <= 32'd0;
    end else begin
      last_grant_q <= last_grant_d;
      rf_rd_q      <= rf_rd_d;
      rf_data_q    <= rf_data_d;
      rf_we_q      <= rf_we_d;
      busy_q       <= busy_d;
    end
  end

  assign rf_rd           = rf_rd_q;
  assign rf_write_data   = rf_data_q;
  assign rf_write_enable = rf_we_q;
  assign busy            = busy_q;

`ifdef WB_BYPASS_EN
  // Forward the committing write to issue during the cycle busy already reads clear.
  assign bp_hit1  = rf_we_q & (rf_rd_q == bp_rs1) & (bp_rs1 != 5'd0);
  assign bp_hit2  = rf_we_q & (rf_rd_q == bp_rs2) & (bp_rs2 != 5'd0);
  assign bp_data1 = rf_data_q;
  assign bp_data2 = rf_data_q;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Scoreboard bench for regfile_wb_arbiter; WB_BYPASS_EN selects the bypass build.
module tb_regfile_wb_arbiter;
  localparam int unsigned N = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         req0_valid, req0_ready, req1_valid, req1_ready;
  logic [4:0]   req0_rd, req1_rd, reserve_rd, rf_rd;
  logic [N-1:0] req0_data, req1_data, rf_write_data;
  logic         reserve_valid, rf_write_enable;
  logic [31:0]  busy;
`ifdef WB_BYPASS_EN
  logic [4:0]   bp_rs1, bp_rs2;
  logic         bp_hit1, bp_hit2;
  logic [N-1:0] bp_data1, bp_data2;
`endif

  regfile_wb_arbiter #(.N(N)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_rd(req0_rd), .req0_data(req0_data),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_rd(req1_rd), .req1_data(req1_data),
    .reserve_valid(reserve_valid), .reserve_rd(reserve_rd),
    .rf_rd(rf_rd), .rf_write_data(rf_write_data), .rf_write_enable(rf_write_enable),
    .busy(busy)
`ifdef WB_BYPASS_EN
    , .bp_rs1(bp_rs1), .bp_rs2(bp_rs2), .bp_hit1(bp_hit1), .bp_hit2(bp_hit2),
    .bp_data1(bp_data1), .bp_data2(bp_data2)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        we;
    logic [4:0]  rd;
    logic [31:0] data;
    logic [31:0] busy;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  // Reference model state.
  logic        m_last;
  logic        m_we;
  logic [4:0]  m_rd;
  logic [31:0] m_data;
  logic [31:0] m_busy;
  logic        g0, g1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_last = 1'b1; m_we = 1'b0; m_rd = 5'd0; m_data = 32'd0; m_busy = 32'd0;
    sb_q.delete();
  endtask

  task automatic idle_inputs();
    req0_valid = 1'b0; req0_rd = 5'd0; req0_data = '0;
    req1_valid = 1'b0; req1_rd = 5'd0; req1_data = '0;
    reserve_valid = 1'b0; reserve_rd = 5'd0;
`ifdef WB_BYPASS_EN
    bp_rs1 = 5'd0; bp_rs2 = 5'd0;
`endif
  endtask

  // Inputs are already driven; check readies, push the expectation, clock, pop and compare.
  task automatic cycle();
    exp_t        e;
    logic        xfer;
    logic [4:0]  srd;
    logic [31:0] sdata;
    #1;
    g1 = req1_valid & (~req0_valid | ~m_last);
    g0 = req0_valid & ~g1;
    chk("req0_ready", 64'(req0_ready), 64'(g0));
    chk("req1_ready", 64'(req1_ready), 64'(g1));
    xfer  = g0 | g1;
    srd   = g1 ? req1_rd : req0_rd;
    sdata = g1 ? req1_data : req0_data;
    e.we   = xfer & (srd != 5'd0);
    e.rd   = xfer ? srd : m_rd;
    e.data = xfer ? sdata : m_data;
    e.busy = m_busy;
`ifdef WB_BYPASS_EN
    if (xfer) e.busy[srd] = 1'b0;
`else
    if (m_we) e.busy[m_rd] = 1'b0;
`endif
    if (reserve_valid && reserve_rd != 5'd0) e.busy[reserve_rd] = 1'b1;
    e.busy[0] = 1'b0;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      chk("sb_empty", 64'd1, 64'd0);
    end else begin
      e = sb_q.pop_front();
      chk("rf_write_enable", 64'(rf_write_enable), 64'(e.we));
      chk("rf_rd", 64'(rf_rd), 64'(e.rd));
      chk("rf_write_data", 64'(rf_write_data), 64'(e.data));
      chk("busy", 64'(busy), 64'(e.busy));
      m_we = e.we; m_rd = e.rd; m_data = e.data; m_busy = e.busy;
      if (xfer) m_last = g1;
    end
`ifdef WB_BYPASS_EN
    bp_rs1 = m_rd;
    bp_rs2 = 5'(m_rd + 5'd1);
    #1;
    chk("bp_hit1", 64'(bp_hit1), 64'(m_we & (m_rd != 5'd0)));
    chk("bp_hit2", 64'(bp_hit2), 64'(m_we & (5'(m_rd + 5'd1) == m_rd)));
    chk("bp_data1", 64'(bp_data1), 64'(m_data));
`endif
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    chk("rst_we", 64'(rf_write_enable), 64'd0);
    chk("rst_rd", 64'(rf_rd), 64'd0);
    chk("rst_data", 64'(rf_write_data), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    logic [4:0]  r0, r1;
    logic [31:0] d0, d1;
    rst = 1'b1;
    idle_inputs();
    model_reset();
    @(posedge clk);
    #1;
    do_reset();

    // Single write from port 0, then drain.
    req0_valid = 1'b1; req0_rd = 5'd5; req0_data = 32'hDEADBEEF;
    cycle();
    idle_inputs();
    cycle();
    cycle();

    // Back-to-back contention alternates 0,1,0,1 from reset.
    do_reset();
    req0_valid = 1'b1; req0_rd = 5'd3; req0_data = 32'h3333_0000;
    req1_valid = 1'b1; req1_rd = 5'd4; req1_data = 32'h4444_0000;
    for (int i = 0; i < 4; i++) begin
      cycle();
      chk("alternate_grant", 64'(g1), 64'(i % 2));
    end
    idle_inputs();
    cycle();

    // Write to x0 is consumed but never enables a write.
    req1_valid = 1'b1; req1_rd = 5'd0; req1_data = 32'h1234;
    cycle();
    idle_inputs();
    cycle();
    chk("x0_no_we", 64'(rf_write_enable), 64'd0);

    // Reserve x7, write it two cycles later, watch busy clear.
    reserve_valid = 1'b1; reserve_rd = 5'd7;
    cycle();
    idle_inputs();
    chk("busy7_set", 64'(busy[7]), 64'd1);
    cycle();
    req0_valid = 1'b1; req0_rd = 5'd7; req0_data = 32'hCAFE_0007;
    cycle();
    idle_inputs();
    cycle();
    chk("busy7_clear", 64'(busy[7]), 64'd0);
    cycle();

    // Re-reserve x9 on the edge its write commits: set wins.
    reserve_valid = 1'b1; reserve_rd = 5'd9;
    req0_valid = 1'b1; req0_rd = 5'd9; req0_data = 32'h9999;
    cycle();
    idle_inputs();
    reserve_valid = 1'b1; reserve_rd = 5'd9;
    cycle();
    idle_inputs();
    chk("busy9_set_wins", 64'(busy[9]), 64'd1);
    cycle();

    // Random traffic honouring hold-until-ready.
    r0 = 5'($urandom_range(0, 31)); d0 = $urandom;
    r1 = 5'($urandom_range(0, 31)); d1 = $urandom;
    for (int i = 0; i < 60; i++) begin
      if (!req0_valid) req0_valid = 1'($urandom_range(0, 1));
      if (!req1_valid) req1_valid = 1'($urandom_range(0, 1));
      req0_rd = r0; req0_data = d0; req1_rd = r1; req1_data = d1;
      reserve_valid = 1'($urandom_range(0, 1));
      reserve_rd    = 5'($urandom_range(0, 31));
      cycle();
      if (g0) begin req0_valid = 1'b0; r0 = 5'($urandom_range(0, 31)); d0 = $urandom; end
      if (g1) begin req1_valid = 1'b0; r1 = 5'($urandom_range(0, 31)); d1 = $urandom; end
    end
    idle_inputs();
    cycle();

    // Asynchronous reset while a write is in flight.
    reserve_valid = 1'b1; reserve_rd = 5'd11;
    cycle();
    idle_inputs();
    req0_valid = 1'b1; req0_rd = 5'd11; req0_data = 32'hABCD_0011;
    cycle();
    idle_inputs();
    chk("inflight_we", 64'(rf_write_enable), 64'd1);
    do_reset();
    req0_valid = 1'b1; req0_rd = 5'd12; req0_data = 32'h12;
    req1_valid = 1'b1; req1_rd = 5'd13; req1_data = 32'h13;
    cycle();
    chk("post_reset_port0", 64'(g0), 64'd1);
    idle_inputs();
    cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
